// File: rtl/vp_pkg.sv
// Shared vector-processor definitions: opcodes, ALU classes, micro-op tags
// and the control-signal bundle that travels down the ID/EXE register.
package vp_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_VEC   = 6'h3F;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] TAG_SCALAR = 2'd0;
    localparam logic [1:0] TAG_VEC    = 2'd1;
    localparam logic [1:0] TAG_VLAST  = 2'd2;
    localparam logic [1:0] TAG_BUBBLE = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_VSEQ = 1'b1
    } seq_state_e;

    // write_n is the active-low memory write enable
    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       write_n;
        logic       branch;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_dst:    1'b0,
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        write_n:    1'b1,
        branch:     1'b0,
        alu_src:    1'b0,
        alu_op:     2'b00
    };

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_vec_sequencer_ctrl_decode.sv
// Combinational opcode decoder: opcode -> control bundle, plus flags telling
// whether the opcode is defined at all and whether it is the vector R-type.
module ctrl_decode
    import vp_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       known,
    output logic       is_vec
);

    // Table lookup; undefined opcodes fall back to the bubble bundle
    always_comb begin
        ctrl   = CTRL_BUBBLE;
        known  = 1'b1;
        is_vec = 1'b0;
        case (opcode)
            OP_RTYPE, OP_VEC: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                is_vec         = (opcode == OP_VEC);
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.write_n = 1'b0;
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_vec_sequencer.sv
// Instruction-decode stage. Scalar ops issue in one cycle; a vector op is
// expanded into vl = shamt+1 element micro-ops tagged with the element index.
//
// Handshake: IF_valid qualifies IF_inst/IF_PC. A word is taken on a rising
// edge where IF_valid=1, flush=0, rst=0 and the sequencer is idle, which is
// exactly when if_stall is low; while if_stall is high IF holds its word and
// the stage ignores it. There is no back-pressure from the EXE side.
module id_vec_sequencer
    import vp_pkg::*;
#(
    parameter int VL_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_valid,
    input  logic [31:0]     IF_inst,
    input  logic [15:0]     IF_PC,
    input  logic            flush,
    output logic            if_stall,
    output logic [15:0]     ID_PC,
    output logic [5:0]      ID_opcode,
    output logic [4:0]      ID_rs_addr,
    output logic [4:0]      ID_rt_addr,
    output logic [4:0]      ID_rd_addr,
    output logic [4:0]      ID_shamt,
    output logic [5:0]      ID_funct,
    output logic [31:0]     ID_immd,
    output logic            ID_RegDst,
    output logic            ID_RegWrite,
    output logic            ID_MemtoReg,
    output logic            ID_branch,
    output logic            ID_ALUSrc,
    output logic            ID_write,
    output logic [1:0]      ID_ALUOp,
    output logic [1:0]      next_state,
    output logic [VL_W-1:0] cnt_i,
    output logic            dbg_state
);

    ctrl_t            dec_ctrl;
    logic             dec_known;
    logic             dec_vec;

    // The output registers double as the instruction latch: during a vector
    // sequence only cnt_q, tag_q and stall_q move.
    logic [31:0]      inst_q;
    logic [15:0]      pc_q;
    ctrl_t            ctrl_q;
    logic [1:0]       tag_q;
    logic [VL_W-1:0]  cnt_q;
    logic             stall_q;
    logic [VL_W-1:0]  vl_last_q;
    seq_state_e       state_q;
    logic [VL_W-1:0]  cnt_inc;

    ctrl_decode u_ctrl_decode (
        .opcode (IF_inst[31:26]),
        .ctrl   (dec_ctrl),
        .known  (dec_known),
        .is_vec (dec_vec)
    );

    assign cnt_inc = cnt_q + VL_W'(1);

    // Sequencer FSM and all output registers; rst and flush both force a bubble
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inst_q    <= '0;
            pc_q      <= '0;
            ctrl_q    <= CTRL_BUBBLE;
            tag_q     <= TAG_BUBBLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            vl_last_q <= '0;
            state_q   <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inst_q    <= '0;
                    pc_q      <= '0;
                    ctrl_q    <= CTRL_BUBBLE;
                    tag_q     <= TAG_BUBBLE;
                    cnt_q     <= '0;
                    stall_q   <= 1'b0;
                    vl_last_q <= '0;
                    if (IF_valid && dec_known) begin
                        inst_q    <= IF_inst;
                        pc_q      <= IF_PC;
                        ctrl_q    <= dec_ctrl;
                        vl_last_q <= VL_W'(IF_inst[10:6]);
                        if (!dec_vec) begin
                            tag_q <= TAG_SCALAR;
                        end else if (IF_inst[10:6] == 5'd0) begin
                            tag_q <= TAG_VLAST;
                        end else begin
                            tag_q   <= TAG_VEC;
                            stall_q <= 1'b1;
                            state_q <= ST_VSEQ;
                        end
                    end
                end
                ST_VSEQ: begin
                    cnt_q <= cnt_inc;
                    if (cnt_inc == vl_last_q) begin
                        tag_q   <= TAG_VLAST;
                        stall_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        tag_q   <= TAG_VEC;
                        stall_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_stall    = stall_q;
    assign ID_PC       = pc_q;
    assign ID_opcode   = inst_q[31:26];
    assign ID_rs_addr  = inst_q[25:21];
    assign ID_rt_addr  = inst_q[20:16];
    assign ID_rd_addr  = inst_q[15:11];
    assign ID_shamt    = inst_q[10:6];
    assign ID_funct    = inst_q[5:0];
    assign ID_immd     = sign_ext16(inst_q[15:0]);
    assign ID_RegDst   = ctrl_q.reg_dst;
    assign ID_RegWrite = ctrl_q.reg_write;
    assign ID_MemtoReg = ctrl_q.mem_to_reg;
    assign ID_branch   = ctrl_q.branch;
    assign ID_ALUSrc   = ctrl_q.alu_src;
    assign ID_write    = ctrl_q.write_n;
    assign ID_ALUOp    = ctrl_q.alu_op;
    assign next_state  = tag_q;
    assign cnt_i       = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_id_vec_sequencer.sv
// Bench for id_vec_sequencer: a queue-based reference model expands each
// accepted instruction into its full list of expected micro-ops.
module tb_id_vec_sequencer;

    localparam int W = 96;
    localparam logic [W-1:0] BUBBLE = {16'h0, 32'h0, 32'h0, 8'h04, 2'd3, 5'd0, 1'b0};

    logic        clk;
    logic        rst;
    logic        IF_valid;
    logic [31:0] IF_inst;
    logic [15:0] IF_PC;
    logic        flush;
    logic        if_stall;
    logic [15:0] ID_PC;
    logic [5:0]  ID_opcode;
    logic [4:0]  ID_rs_addr, ID_rt_addr, ID_rd_addr, ID_shamt;
    logic [5:0]  ID_funct;
    logic [31:0] ID_immd;
    logic        ID_RegDst, ID_RegWrite, ID_MemtoReg, ID_branch, ID_ALUSrc, ID_write;
    logic [1:0]  ID_ALUOp;
    logic [1:0]  next_state;
    logic [4:0]  cnt_i;
    logic        dbg_state;

    logic [W-1:0] exp_q[$];
    int pass_cnt = 0;
    int chk_cnt  = 0;

    id_vec_sequencer #(.VL_W(5)) dut (
        .clk(clk), .rst(rst), .IF_valid(IF_valid), .IF_inst(IF_inst), .IF_PC(IF_PC),
        .flush(flush), .if_stall(if_stall), .ID_PC(ID_PC), .ID_opcode(ID_opcode),
        .ID_rs_addr(ID_rs_addr), .ID_rt_addr(ID_rt_addr), .ID_rd_addr(ID_rd_addr),
        .ID_shamt(ID_shamt), .ID_funct(ID_funct), .ID_immd(ID_immd),
        .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg),
        .ID_branch(ID_branch), .ID_ALUSrc(ID_ALUSrc), .ID_write(ID_write),
        .ID_ALUOp(ID_ALUOp), .next_state(next_state), .cnt_i(cnt_i), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        rst = 1'b1; IF_valid = 1'b0; IF_inst = '0; IF_PC = '0; flush = 1'b0;
    end

    // Observed output bundle in a fixed order
    function automatic logic [W-1:0] actual();
        return {ID_PC, ID_opcode, ID_rs_addr, ID_rt_addr, ID_rd_addr, ID_shamt, ID_funct,
                ID_immd, ID_RegDst, ID_RegWrite, ID_MemtoReg, ID_branch, ID_ALUSrc,
                ID_write, ID_ALUOp, next_state, cnt_i, if_stall};
    endfunction

    // {defined, RegDst, RegWrite, MemtoReg, branch, ALUSrc, write, ALUOp}
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00, 6'h3F: return 9'b1_1_1_0_0_0_1_10;
            6'h08:        return 9'b1_0_1_0_0_1_1_00;
            6'h23:        return 9'b1_0_1_1_0_1_1_00;
            6'h2B:        return 9'b1_0_0_0_0_1_0_00;
            6'h04:        return 9'b1_0_0_0_1_0_1_01;
            default:      return 9'b0_0_0_0_0_0_1_00;
        endcase
    endfunction

    function automatic logic [W-1:0] mk(input logic [15:0] pc, input logic [31:0] inst,
                                        input logic [7:0] c, input logic [1:0] tag,
                                        input logic [4:0] cnt, input logic stall);
        logic [15:0] imm;
        imm = inst[15:0];
        return {pc, inst, {{16{imm[15]}}, imm}, c, tag, cnt, stall};
    endfunction

    // Expand one accepted instruction into every micro-op it should produce
    task automatic expand(input logic [31:0] inst, input logic [15:0] pc);
        logic [8:0] c;
        int vl;
        c = ref_ctrl(inst[31:26]);
        if (!c[8]) begin
            exp_q.push_back(BUBBLE);
        end else if (inst[31:26] == 6'h3F) begin
            vl = int'(inst[10:6]) + 1;
            for (int k = 0; k < vl; k++)
                exp_q.push_back(mk(pc, inst, c[7:0], (k == vl - 1) ? 2'd2 : 2'd1,
                                   5'(k), (k != vl - 1)));
        end else begin
            exp_q.push_back(mk(pc, inst, c[7:0], 2'd0, 5'd0, 1'b0));
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, sample after the edge
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [15:0] pc,
                         input logic fl, input logic r, output logic [W-1:0] e);
        @(negedge clk);
        IF_valid = v; IF_inst = inst; IF_PC = pc; flush = fl; rst = r;
        if (r || fl) begin
            exp_q.delete();
            e = BUBBLE;
        end else begin
            if (exp_q.size() == 0 && v) expand(inst, pc);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = BUBBLE;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        cycle(1'b1, 32'h2001_0005, 16'h0040, 1'b0, 1'b1, e);
        chk_cnt++; if (actual() !== e) $display("FAIL reset: got %h exp %h", actual(), e); else pass_cnt++;
        cycle(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, e);
        chk_cnt++; if (actual() !== e) $display("FAIL idle_bubble: got %h exp %h", actual(), e); else pass_cnt++;
        chk_cnt++;
        if (ID_write !== 1'b1 || next_state !== 2'd3 || if_stall !== 1'b0)
            $display("FAIL bubble_fields: write %b tag %0d stall %b exp 1 3 0", ID_write, next_state, if_stall);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        logic [5:0] ops[3] = '{6'h23, 6'h2B, 6'h04};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, {ops[i], 5'd3, 5'd9, 16'hFFF0}, 16'h0100 + 16'(4 * i), 1'b0, 1'b0, e);
            chk_cnt++; if (actual() !== e) $display("FAIL b2b_%0d: got %h exp %h", i, actual(), e); else pass_cnt++;
            chk_cnt++;
            if (ID_immd !== 32'hFFFF_FFF0 || ID_write !== (ops[i] != 6'h2B) || if_stall !== 1'b0)
                $display("FAIL b2b_imm_%0d: immd %h write %b stall %b", i, ID_immd, ID_write, if_stall);
            else pass_cnt++;
        end
    endtask

    task automatic test_vec4();
        logic [W-1:0] e;
        logic [1:0] tags[4] = '{2'd1, 2'd1, 2'd1, 2'd2};
        for (int k = 0; k < 4; k++) begin
            // after the first cycle IF offers a different word, which must be ignored
            cycle(1'b1, (k == 0) ? {6'h3F, 5'd1, 5'd2, 5'd3, 5'd3, 6'h20} : 32'h2000_1234,
                  16'h0200, 1'b0, 1'b0, e);
            chk_cnt++; if (actual() !== e) $display("FAIL vec4_%0d: got %h exp %h", k, actual(), e); else pass_cnt++;
            chk_cnt++;
            if (cnt_i !== 5'(k) || next_state !== tags[k] || if_stall !== (k < 3))
                $display("FAIL vec4_tag_%0d: cnt %0d tag %0d stall %b", k, cnt_i, next_state, if_stall);
            else pass_cnt++;
        end
        cycle(1'b1, {6'h08, 5'd4, 5'd5, 16'h0007}, 16'h0204, 1'b0, 1'b0, e);
        chk_cnt++;
        if (actual() !== e || next_state !== 2'd0) $display("FAIL vec4_addi: got %h exp %h", actual(), e);
        else pass_cnt++;
    endtask

    task automatic test_vec_edges();
        logic [W-1:0] e;
        cycle(1'b1, {6'h3F, 5'd7, 5'd8, 5'd9, 5'd0, 6'h22}, 16'h0300, 1'b0, 1'b0, e);
        chk_cnt++;
        if (actual() !== e || next_state !== 2'd2 || cnt_i !== 5'd0 || if_stall !== 1'b0)
            $display("FAIL vl1: got %h exp %h", actual(), e);
        else pass_cnt++;
        for (int k = 0; k < 32; k++) begin
            cycle(1'b1, {6'h3F, 5'd10, 5'd11, 5'd12, 5'd31, 6'h20}, 16'h0304, 1'b0, 1'b0, e);
            chk_cnt++; if (actual() !== e) $display("FAIL vl32_%0d: got %h exp %h", k, actual(), e); else pass_cnt++;
        end
        chk_cnt++;
        if (cnt_i !== 5'd31 || next_state !== 2'd2)
            $display("FAIL vl32_end: cnt %0d tag %0d exp 31 2", cnt_i, next_state);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [W-1:0] e;
        for (int k = 0; k < 3; k++)
            cycle(1'b1, {6'h3F, 5'd1, 5'd1, 5'd1, 5'd7, 6'h20}, 16'h0400, 1'b0, 1'b0, e);
        chk_cnt++; if (cnt_i !== 5'd2 || if_stall !== 1'b1) $display("FAIL pre_flush: cnt %0d stall %b", cnt_i, if_stall); else pass_cnt++;
        cycle(1'b1, {6'h3F, 5'd1, 5'd1, 5'd1, 5'd7, 6'h20}, 16'h0400, 1'b1, 1'b0, e);
        chk_cnt++; if (actual() !== e) $display("FAIL flush: got %h exp %h", actual(), e); else pass_cnt++;
        cycle(1'b1, {6'h00, 5'd2, 5'd3, 5'd4, 5'd0, 6'h20}, 16'h0500, 1'b0, 1'b0, e);
        chk_cnt++; if (actual() !== e) $display("FAIL post_flush: got %h exp %h", actual(), e); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        for (int k = 0; k < 2; k++)
            cycle(1'b1, {6'h3F, 5'd5, 5'd6, 5'd7, 5'd7, 6'h20}, 16'h0600, 1'b0, 1'b0, e);
        cycle(1'b1, {6'h3F, 5'd5, 5'd6, 5'd7, 5'd7, 6'h20}, 16'h0600, 1'b0, 1'b1, e);
        chk_cnt++; if (actual() !== e) $display("FAIL reset_mid: got %h exp %h", actual(), e); else pass_cnt++;
        cycle(1'b1, {6'h3A, 26'h155_AAAA}, 16'h0700, 1'b0, 1'b0, e);
        chk_cnt++; if (actual() !== e) $display("FAIL undef_op: got %h exp %h", actual(), e); else pass_cnt++;
        cycle(1'b1, {6'h2B, 5'd1, 5'd2, 16'h0010}, 16'h0704, 1'b0, 1'b0, e);
        chk_cnt++; if (actual() !== e) $display("FAIL after_undef: got %h exp %h", actual(), e); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [5:0] op_tbl[8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h3F, 6'h3A};
        logic [31:0] inst;
        logic [15:0] pc;
        logic v;
        int errs;
        inst = '0; pc = '0; v = 1'b0; errs = 0;
        for (int n = 0; n < 600; n++) begin
            // IF holds its word while the model still owes micro-ops
            if (exp_q.size() == 0) begin
                v    = ($urandom_range(0, 9) != 0);
                inst = {op_tbl[$urandom_range(0, 7)], 26'($urandom)};
                if ($urandom_range(0, 15) == 0) inst[31:26] = 6'($urandom);
                pc   = 16'($urandom);
            end
            cycle(v, inst, pc, ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0), e);
            chk_cnt++;
            if (actual() !== e) begin
                errs++;
                if (errs <= 10) $display("FAIL random_%0d: got %h exp %h", n, actual(), e);
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_vec4();
        test_vec_edges();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
